// File: rtl/hilo_mul_ctrl.sv
// HI/LO register pair and multi-cycle sequencer for the shared multiplier.
// Holds operands stable for LATENCY cycles, then writes the product.
module hilo_mul_ctrl #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_req,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        mul_signed_q, mul_signed_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state: accept requests in IDLE, count down and write in RUN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d      = a;
              mul_b_d      = b;
              mul_signed_d = (op == OP_MULT);
              cnt_d        = CNT_INIT;
              busy_d       = 1'b1;
              state_d      = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          hi_d    = mul_z[63:32];
          lo_d    = mul_z[31:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      mul_signed_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_signed = mul_signed_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stall      = busy_q & (start | rd_req);

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: LATENCY=4 and LATENCY=1 instances share stimulus,
// each checked every cycle against a write-time model plus literal pins.
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rd_req, flush;

  logic [31:0] ma_o [2];
  logic [31:0] mb_o [2];
  logic        ms_o [2];
  logic [63:0] mz   [2];
  logic [31:0] hi_o [2];
  logic [31:0] lo_o [2];
  logic        bz_o [2];
  logic        dn_o [2];
  logic        st_o [2];

  int vecs = 0;
  int errs = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(logic [31:0] x, logic [31:0] y,
                                        logic s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  assign mz[0] = mul64(ma_o[0], mb_o[0], ms_o[0]);
  assign mz[1] = mul64(ma_o[1], mb_o[1], ms_o[1]);

  hilo_mul_ctrl #(.LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .flush(flush),
    .mul_a(ma_o[0]), .mul_b(mb_o[0]), .mul_signed(ms_o[0]),
    .mul_z(mz[0]), .hi(hi_o[0]), .lo(lo_o[0]),
    .busy(bz_o[0]), .done(dn_o[0]), .stall(st_o[0])
  );

  hilo_mul_ctrl #(.LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .flush(flush),
    .mul_a(ma_o[1]), .mul_b(mb_o[1]), .mul_signed(ms_o[1]),
    .mul_z(mz[1]), .hi(hi_o[1]), .lo(lo_o[1]),
    .busy(bz_o[1]), .done(dn_o[1]), .stall(st_o[1])
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a multiply accepted at edge e writes at edge e+LAT unless
  // flushed or reset first; busy means a write is still pending.
  int          lat [2] = '{4, 1};
  int          ecnt = 0;
  bit          m_pend [2];
  int          m_wr   [2];
  logic [63:0] m_prod [2];
  logic [31:0] m_hi [2], m_lo [2], m_a [2], m_b [2];
  logic        m_s [2], m_done [2];

  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 0; m_done[i] = 0;
        m_hi[i] = 0; m_lo[i] = 0;
        m_a[i] = 0; m_b[i] = 0; m_s[i] = 0;
      end else begin
        m_done[i] = 0;
        if (m_pend[i]) begin
          if (flush) m_pend[i] = 0;
          else if (ecnt == m_wr[i]) begin
            {m_hi[i], m_lo[i]} = m_prod[i];
            m_pend[i] = 0;
            m_done[i] = 1;
          end
        end else if (start && !flush) begin
          if (op == 3'd0 || op == 3'd1) begin
            m_pend[i] = 1;
            m_wr[i]   = ecnt + lat[i];
            m_a[i] = a; m_b[i] = b; m_s[i] = (op == 3'd0);
            m_prod[i] = (op == 3'd0)
                      ? 64'($signed(a) * $signed(b) )
                      : mul64(a, b, 1'b0);
            if (op == 3'd0)
              m_prod[i] = mul64(a, b, 1'b1);
          end else if (op == 3'd2) m_hi[i] = a;
          else if (op == 3'd3) m_lo[i] = a;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("hi[%0d]", i), 64'(hi_o[i]), 64'(m_hi[i]));
        chk($sformatf("lo[%0d]", i), 64'(lo_o[i]), 64'(m_lo[i]));
        chk($sformatf("busy[%0d]", i), 64'(bz_o[i]), 64'(m_pend[i]));
        chk($sformatf("done[%0d]", i), 64'(dn_o[i]), 64'(m_done[i]));
        chk($sformatf("stall[%0d]", i), 64'(st_o[i]),
            64'(m_pend[i] & (start | rd_req)));
        chk($sformatf("mul_a[%0d]", i), 64'(ma_o[i]), 64'(m_a[i]));
        chk($sformatf("mul_b[%0d]", i), 64'(mb_o[i]), 64'(m_b[i]));
        chk($sformatf("msign[%0d]", i), 64'(ms_o[i]), 64'(m_s[i]));
      end
    end
  end

  task automatic step(bit st, logic [2:0] o, logic [31:0] aa,
                      logic [31:0] bb, bit rd = 0, bit fl = 0);
    start = st; op = o; a = aa; b = bb; rd_req = rd; flush = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 3'd7, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n = 0; start = 0; op = 0; a = 0; b = 0; rd_req = 0; flush = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk_on = 1'b1;
    chk("rst_hi", 64'(hi_o[0]), 64'd0);
    chk("rst_busy", 64'(bz_o[0]), 64'd0);
    rst_n = 1;
    idle(2);

    step(1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("t1_busy_e0", 64'(bz_o[0]), 64'd1);
    idle(1);
    chk("t1_l1_hi", 64'(hi_o[1]), 64'hFFFF_FFFF);
    chk("t1_l1_done", 64'(dn_o[1]), 64'd1);
    idle(2);
    chk("t1_busy_e3", 64'(bz_o[0]), 64'd1);
    chk("t1_hi_old", 64'(hi_o[0]), 64'd0);
    idle(1);
    chk("t1_hi", 64'(hi_o[0]), 64'hFFFF_FFFF);
    chk("t1_lo", 64'(lo_o[0]), 64'hFFFF_FFFE);
    chk("t1_done", 64'(dn_o[0]), 64'd1);
    chk("t1_busy_off", 64'(bz_o[0]), 64'd0);
    idle(1);
    chk("t1_done_off", 64'(dn_o[0]), 64'd0);

    step(1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("t2_msign", 64'(ms_o[0]), 64'd0);
    idle(4);
    chk("t2_hi", 64'(hi_o[0]), 64'h0000_0001);
    chk("t2_lo", 64'(lo_o[0]), 64'hFFFF_FFFE);

    step(1, 3'd2, 32'h1234_5678, 32'd0);
    chk("t3_hi", 64'(hi_o[0]), 64'h1234_5678);
    step(1, 3'd3, 32'h9ABC_DEF0, 32'd0);
    chk("t3_lo", 64'(lo_o[0]), 64'h9ABC_DEF0);
    chk("t3_busy", 64'(bz_o[0]), 64'd0);
    step(1, 3'd5, 32'h5555_5555, 32'd0);
    chk("t3_rsvd", 64'(hi_o[0]), 64'h1234_5678);
    idle(1);

    step(1, 3'd0, 32'd3, 32'd5, 1);
    for (int k = 0; k < 4; k++) step(1, 3'd1, 32'd7, 32'd9, 1);
    chk("t4_first", 64'(lo_o[0]), 64'd15);
    step(1, 3'd1, 32'd7, 32'd9, 1);
    chk("t4_accept", 64'(bz_o[0]), 64'd1);
    idle(4);
    chk("t4_second", 64'(lo_o[0]), 64'd63);
    chk("t4_done", 64'(dn_o[0]), 64'd1);
    idle(1);

    step(1, 3'd0, 32'd2, 32'd2);
    idle(3);
    step(0, 3'd7, 32'd0, 32'd0, 0, 1);
    chk("t5_keep_lo", 64'(lo_o[0]), 64'd63);
    chk("t5_no_done", 64'(dn_o[0]), 64'd0);
    chk("t5_busy", 64'(bz_o[0]), 64'd0);
    chk("t5_l1_lo", 64'(lo_o[1]), 64'd4);
    step(1, 3'd2, 32'hDEAD_BEEF, 32'd0, 0, 1);
    chk("t5_drop", 64'(hi_o[0]), 64'd0);
    idle(1);

    step(1, 3'd0, 32'd10, 32'd10);
    idle(1);
    rst_n = 0;
    idle(1);
    chk("t6_hi", 64'(hi_o[0]), 64'd0);
    chk("t6_lo", 64'(lo_o[0]), 64'd0);
    chk("t6_busy", 64'(bz_o[0]), 64'd0);
    rst_n = 1;
    idle(5);
    chk("t6_nowrite", 64'(lo_o[0]), 64'd0);

    step(1, 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    idle(4);
    chk("t7_hi", 64'(hi_o[0]), 64'd0);
    chk("t7_lo", 64'(lo_o[0]), 64'd15);
    step(1, 3'd0, 32'hFFFF_FFFD, 32'd5);
    idle(4);
    chk("t7_nhi", 64'(hi_o[0]), 64'hFFFF_FFFF);
    chk("t7_nlo", 64'(lo_o[0]), 64'hFFFF_FFF1);
    idle(2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
